// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART RAM loader.
// Frame geometry, FSM states and a word-to-byte helper.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    SEND,
    POST_SEND
  } state_e;

  localparam int FRAME_BITS     = 10;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 16;

  function automatic logic [7:0] word_byte(
    input logic [31:0] w,
    input logic [1:0]  idx
  );
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_shift.sv
// One-byte UART transmitter: start, 8 data bits MSB first, stop.
// done is high during the last clk of the stop bit so a new load can follow gaplessly.
module uart_tx_shift
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam logic [CNT_W-1:0] BIT_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] NBITS = 4'(FRAME_BITS - 1);

  logic             busy;
  logic [8:0]       sh;
  logic [3:0]       rem;
  logic [CNT_W-1:0] cnt;

  assign done = busy && (cnt == '0) && (rem == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      txd  <= 1'b1;
      busy <= 1'b0;
      sh   <= '1;
      rem  <= 4'd0;
      cnt  <= '0;
    end else if (load) begin
      txd  <= 1'b0;
      sh   <= {data, 1'b1};
      rem  <= NBITS;
      cnt  <= BIT_CNT;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else if (rem == 4'd0) begin
        busy <= 1'b0;
        txd  <= 1'b1;
      end else begin
        txd <= sh[8];
        sh  <= {sh[7:0], 1'b1};
        rem <= rem - 4'd1;
        cnt <= BIT_CNT;
      end
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART loader/dumper between a serial pin pair and RAM port 2.
// Define UART_ECHO_EN to echo datai on datao while receiving.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [31:0] CTRL_ADDR    = 32'h0007_0000,
  parameter logic [31:0] DATA_BASE    = 32'h0000_0000,
  parameter int          TX_WORDS     = 2,
  parameter int          CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        datai,
  input  logic [31:0] rramdata,
  output logic        datao,
  output logic        wram,
  output logic [31:0] ramaddress,
  output logic [31:0] wramdata
);

  localparam logic [CNT_W-1:0] BIT_CNT =
    CNT_W'(CLKS_PER_BIT - 1);
  // first sample lands mid-way through the first data bit
  localparam logic [CNT_W-1:0] FIRST_CNT =
    CNT_W'(CLKS_PER_BIT + CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(FRAME_BITS - 2);
  localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam logic [31:0] LAST_WORD = 32'(TX_WORDS - 1);

  state_e           state;
  logic [CNT_W-1:0] rxcnt;
  logic [3:0]       rxbit;
  logic [7:0]       rxbyte;
  logic [1:0]       rxbytes;
  logic [23:0]      rxword;
  logic [31:0]      wptr;
  logic [31:0]      txword;
  logic [1:0]       bsel;
  logic [31:0]      widx;
  logic             fetch;
  logic             last_word;
  logic             tx_load;
  logic [7:0]       tx_byte;
  logic             tx_txd;
  logic             tx_done;

  assign last_word = (widx == LAST_WORD);

  uart_tx_shift #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk (clk),
    .rst (nrst),
    .load(tx_load),
    .data(tx_byte),
    .txd (tx_txd),
    .done(tx_done)
  );

  // next word is prefetched so it is on rramdata when its first byte is due
  always_comb begin
    tx_load = 1'b0;
    tx_byte = word_byte(rramdata, 2'd0);
    if (state == SEND) begin
      if (fetch) begin
        tx_load = 1'b1;
      end else if (tx_done) begin
        if (bsel != 2'd0) begin
          tx_load = 1'b1;
          tx_byte = word_byte(txword, bsel);
        end else if (!last_word) begin
          tx_load = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state      <= IDLE;
      datao      <= 1'b1;
      wram       <= 1'b0;
      ramaddress <= CTRL_ADDR;
      wramdata   <= '0;
      rxcnt      <= '0;
      rxbit      <= 4'd0;
      rxbyte     <= '0;
      rxbytes    <= 2'd0;
      rxword     <= '0;
      wptr       <= DATA_BASE;
      txword     <= '0;
      bsel       <= 2'd0;
      widx       <= '0;
      fetch      <= 1'b0;
    end else begin
      wram <= 1'b0;
      unique case (state)
        IDLE: begin
          ramaddress <= CTRL_ADDR;
          datao      <= 1'b1;
          if (!datai) begin
            state <= RECEIVE;
            rxcnt <= FIRST_CNT;
            rxbit <= 4'd0;
`ifdef UART_ECHO_EN
            datao <= datai;
`endif
          end else if (!wram && rramdata == 32'd1) begin
            state      <= SEND;
            ramaddress <= DATA_BASE;
            widx       <= '0;
            fetch      <= 1'b1;
          end
        end
        RECEIVE: begin
          ramaddress <= CTRL_ADDR;
`ifdef UART_ECHO_EN
          datao <= datai;
`else
          datao <= 1'b1;
`endif
          if (rxcnt != '0) begin
            rxcnt <= rxcnt - 1'b1;
          end else begin
            rxcnt <= BIT_CNT;
            if (rxbit != LAST_BIT) begin
              rxbyte <= {rxbyte[6:0], datai};
              rxbit  <= rxbit + 4'd1;
            end else begin
              state <= IDLE;
              if (datai) begin
                rxword  <= {rxword[15:0], rxbyte};
                rxbytes <= rxbytes + 2'd1;
                if (rxbytes == LAST_BYTE) begin
                  wram       <= 1'b1;
                  ramaddress <= wptr;
                  wramdata   <= {rxword, rxbyte};
                  wptr       <= wptr + 32'd1;
                end
              end
            end
          end
        end
        SEND: begin
          datao <= tx_txd;
          if (fetch) begin
            fetch      <= 1'b0;
            txword     <= rramdata;
            bsel       <= 2'd1;
            ramaddress <= DATA_BASE + 32'd1;
          end else if (tx_done) begin
            if (bsel != 2'd0) begin
              bsel <= bsel + 2'd1;
            end else if (last_word) begin
              state      <= POST_SEND;
              wram       <= 1'b1;
              ramaddress <= CTRL_ADDR;
              wramdata   <= '0;
            end else begin
              txword     <= rramdata;
              bsel       <= 2'd1;
              widx       <= widx + 32'd1;
              ramaddress <= DATA_BASE + widx + 32'd2;
            end
          end
        end
        POST_SEND: begin
          datao      <= 1'b1;
          ramaddress <= CTRL_ADDR;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: RAM model, write scoreboard, serial decoder.
// RX words come from a vector table; send/reset corners are hand sequences.
module tb_uart_loader;

  localparam logic [31:0] CTRL = 32'h0007_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  b [4];
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic        datai;
  logic [31:0] rramdata;
  logic        datao;
  logic        wram;
  logic [31:0] ramaddress;
  logic [31:0] wramdata;

  logic [31:0] mem [16];
  logic [31:0] ctrl;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;

  int checks = 0;
  int errors = 0;

  wr_t        wexp [$];
  logic [7:0] txq [$];
  int         wcount = 0;
  logic       prev_w = 1'b0;
  logic       tx_mon;
  logic       last_rx;
  logic [31:0] wp;

  bit         dec_on = 0;
  int         dec_n = 0;
  logic [7:0] dec_sh = '0;
  int         cyc = 0;
  int         last_start = 0;
  int         burst = 0;
  int         tx_frames = 0;

  vec_t vecs [4];

  always #5 clk = ~clk;

  uart_loader dut (
    .clk       (clk),
    .nrst      (nrst),
    .datai     (datai),
    .rramdata  (rramdata),
    .datao     (datao),
    .wram      (wram),
    .ramaddress(ramaddress),
    .wramdata  (wramdata)
  );

  always_comb begin
    rramdata = 32'h0;
    if (ramaddress == CTRL)
      rramdata = ctrl;
    else if (ramaddress < 32'd16)
      rramdata = mem[ramaddress[3:0]];
  end

  always @(posedge clk) begin
    if (wram) begin
      if (ramaddress == CTRL) ctrl <= wramdata;
      else if (ramaddress < 32'd16) mem[ramaddress[3:0]] <= wramdata;
    end
    if (cpu_we) begin
      if (cpu_addr == CTRL) ctrl <= cpu_data;
      else if (cpu_addr < 32'd16) mem[cpu_addr[3:0]] <= cpu_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_none(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  // RAM write scoreboard
  always @(negedge clk) begin
    if (wram) begin
      wr_t e;
      wcount++;
      chk("wram_width", 32'(prev_w), 32'd0);
      if (wexp.size() == 0) begin
        fail_none("unexpected_write", ramaddress);
      end else begin
        e = wexp.pop_front();
        chk("wr_addr", ramaddress, e.addr);
        chk("wr_data", wramdata, e.data);
      end
    end
    prev_w = wram;
  end

  // serial decoder for datao while a send is being observed
  always @(negedge clk) begin
    cyc++;
    if (nrst || !tx_mon) begin
      dec_on = 0;
      burst = 0;
      if (!tx_mon) tx_frames = 0;
    end else if (!dec_on) begin
      if (datao == 1'b0) begin
        dec_on = 1;
        dec_n = 0;
        dec_sh = '0;
        if (burst > 0) chk("tx_gap", 32'(cyc - last_start), 32'd10);
        last_start = cyc;
        burst++;
      end
    end else begin
      dec_n++;
      if (dec_n <= 8) begin
        dec_sh = {dec_sh[6:0], datao};
      end else begin
        dec_on = 0;
        tx_frames++;
        chk("tx_stop", 32'(datao), 32'd1);
        if (txq.size() == 0) fail_none("tx_extra_frame", 32'(dec_sh));
        else chk("tx_byte", 32'(dec_sh), 32'(txq.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 datai = 1'b1;
    end
    last_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {1'b0, b, stop};
    for (int i = 9; i >= 0; i--) begin
      @(posedge clk);
      #1 datai = f[i];
      @(negedge clk);
`ifdef UART_ECHO_EN
      chk("rx_echo", 32'(datao), 32'(last_rx));
`else
      chk("rx_idle_high", 32'(datao), 32'd1);
`endif
      last_rx = f[i];
    end
  endtask

  task automatic send_word(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [31:0] exp);
    wexp.push_back('{wp, exp});
    wp = wp + 32'd1;
    send_frame(b0, 1'b1);
    send_frame(b1, 1'b1);
    send_frame(b2, 1'b1);
    send_frame(b3, 1'b1);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    cpu_we = 1'b1;
    cpu_addr = a;
    cpu_data = d;
    @(posedge clk);
    #1 cpu_we = 1'b0;
  endtask

  task automatic push_tx(input logic [31:0] w0, input logic [31:0] w1);
    for (int k = 3; k >= 0; k--) txq.push_back(w0[8*k +: 8]);
    for (int k = 3; k >= 0; k--) txq.push_back(w1[8*k +: 8]);
  endtask

  task automatic do_send(input logic [31:0] w0, input logic [31:0] w1,
                         input bit poke);
    push_tx(w0, w1);
    wexp.push_back('{CTRL, 32'h0});
    tx_mon = 1'b1;
    cpu_write(CTRL, 32'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (poke) datai = !(i >= 30 && i < 45);
      if (ctrl == 32'h0) break;
    end
    datai = 1'b1;
    chk("send_ctrl_cleared", ctrl, 32'h0);
    idle(3);
    @(negedge clk);
    chk("tx_frames", 32'(tx_frames), 32'd8);
    chk("tx_left", 32'(txq.size()), 32'd0);
    chk("post_datao", 32'(datao), 32'd1);
    chk("post_addr", ramaddress, CTRL);
    tx_mon = 1'b0;
  endtask

  initial begin
    vecs[0].b = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
    vecs[0].exp = 32'hF0F0_F0F0;
    vecs[1].b = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
    vecs[1].exp = 32'hF0F0_F0F0;
    vecs[2].b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    vecs[2].exp = 32'hDEAD_BEEF;
    vecs[3].b = '{8'h00, 8'hFF, 8'h01, 8'h80};
    vecs[3].exp = 32'h00FF_0180;

    nrst = 1'b1;
    datai = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;
    tx_mon = 1'b0;
    last_rx = 1'b1;
    wp = 32'd0;
    cpu_write(CTRL, 32'h0);
    @(negedge clk);
    chk("rst_datao", 32'(datao), 32'd1);
    chk("rst_wram", 32'(wram), 32'd0);
    chk("rst_addr", ramaddress, CTRL);
    chk("rst_wdata", wramdata, 32'h0);
    @(posedge clk);
    #1 nrst = 1'b0;
    idle(3);

    // table-driven RX words, all frames back-to-back
    begin
      int w0;
      w0 = wcount;
      for (int v = 0; v < 2; v++)
        send_word(vecs[v].b[0], vecs[v].b[1], vecs[v].b[2],
                  vecs[v].b[3], vecs[v].exp);
      idle(4);
      chk("rx_wram_pulses", 32'(wcount - w0), 32'd2);
      chk("mem0", mem[0], 32'hF0F0_F0F0);
      chk("mem1", mem[1], 32'hF0F0_F0F0);
    end

    do_send(32'hF0F0_F0F0, 32'hF0F0_F0F0, 1'b0);

    for (int v = 2; v < 4; v++)
      send_word(vecs[v].b[0], vecs[v].b[1], vecs[v].b[2],
                vecs[v].b[3], vecs[v].exp);
    idle(4);

    // framing error: byte dropped, following bytes pack cleanly
    send_frame(8'h11, 1'b0);
    idle(3);
    send_word(8'h12, 8'h34, 8'h56, 8'h78, 32'h1234_5678);
    idle(4);
    chk("mem4", mem[4], 32'h1234_5678);

    cpu_write(32'd0, 32'h8001_7E3C);
    cpu_write(32'd1, 32'hDEAD_BEEF);
    do_send(32'h8001_7E3C, 32'hDEAD_BEEF, 1'b1);
    idle(3);

    // reset during SEND
    push_tx(32'h8001_7E3C, 32'hDEAD_BEEF);
    tx_mon = 1'b1;
    cpu_write(CTRL, 32'd1);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (ramaddress == 32'd0) seen = 1;
      end
      chk("send_entered", 32'(seen), 32'd1);
    end
    repeat (24) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midsend_datao", 32'(datao), 32'd1);
    chk("midsend_wram", 32'(wram), 32'd0);
    chk("midsend_addr", ramaddress, CTRL);
    chk("midsend_wdata", wramdata, 32'h0);
    chk("midsend_ctrl_kept", ctrl, 32'd1);
    txq.delete();
    tx_mon = 1'b0;
    cpu_write(CTRL, 32'h0);
    @(posedge clk);
    #1 nrst = 1'b0;
    wp = 32'd0;
    idle(3);
    @(negedge clk);
    chk("after_rst_datao", 32'(datao), 32'd1);

    // reset mid-word: partial bytes lost, pointer back at base
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1 nrst = 1'b0;
    idle(3);
    send_word(8'hC0, 8'hFF, 8'hEE, 8'h03, 32'hC0FF_EE03);
    idle(10);
    chk("mem0_after_rst", mem[0], 32'hC0FF_EE03);
    chk("wr_pending", 32'(wexp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
